brc_serial_ctrl: RTL
====================

// Module: brc_serial_ctrl
// PURPOSE
//  Multi-cycle branch comparator controller. It reuses one SLICE_W-bit compare slice and steps it
//  from the MSB slice down to bit 0, producing branch-less and branch-equal flags for branch
//  resolution. It has a valid/ready handshake on each side. This is the area-reduced
//  alternative to the fully parallel 32-bit comparator chain in branch resolution.
// PARAMETERS
//  DATA_W   32  operand width
//  SLICE_W   4  bits compared per cycle; DATA_W % SLICE_W must be 0, else $error at elaboration
//  (derived) NSLICE = DATA_W/SLICE_W  (8 at defaults)
// PORTS
//  i_clk        in   1        clock, rising edge
//  i_rst        in   1        synchronous reset, active-high
//  i_valid      in   1        request valid
//  o_ready      out  1        controller can accept a request
//  i_rs1_data   in   DATA_W   operand rs1
//  i_rs2_data   in   DATA_W   operand rs2
//  i_br_un      in   1        1 = unsigned compare, 0 = signed (two's complement)
//  o_valid      out  1        result valid
//  i_ready      in   1        consumer accepts result
//  o_br_less    out  1        rs1 < rs2 under the selected signedness
//  o_br_equal   out  1        rs1 == rs2
// BEHAVIOUR
//  - Reset: state=IDLE, o_valid=0, o_br_less=0, o_br_equal=0. o_ready=0 while i_rst=1.
//  - Reset mid-operation aborts the compare. The request is discarded and no o_valid is produced.
//  - FSM states:
//    - IDLE: o_ready=1. i_valid&&o_ready latches the operands and i_br_un, sets idx=NSLICE-1,
//      sets decided=0, and moves to CMP.
//    - CMP: o_ready=0. Each edge compares the latched slice [idx*SLICE_W +: SLICE_W] unsigned.
//      idx decrements each edge. After the idx=0 edge the FSM moves to DONE.
//    - DONE: o_valid=1; o_br_less and o_br_equal are held stable. i_ready=1 moves to IDLE on
//      that edge. o_ready stays 0 in DONE; there is no accept-while-draining.
//  - Signed mode: both operand MSBs are inverted when latched. Unsigned compare of the modified
//    values then equals the signed result.
//  - Slice merge is MSB-first:
//    - While decided=0 and the slices are equal, nothing is recorded.
//    - At the first unequal slice: less<=slice_lt and decided<=1. Later slices are ignored.
//    - At DONE, o_br_equal=~decided and o_br_less=less (0 when equal).
//  - Latency (base build): o_valid rises exactly NSLICE edges after the accepting edge.
//    - Throughput: one request per NSLICE+2 cycles minimum.
//  - i_valid outside IDLE is ignored. The operands need not be held after acceptance.
//  - Back-pressure: o_valid && !i_ready holds all outputs unchanged indefinitely.
//  - o_valid falls on the edge where i_ready=1 is sampled in DONE.
// CONFIGURATION
//  BRC_EARLY_EXIT_EN defined:
//    - CMP moves to DONE on the edge that processes the first unequal slice.
//    - Latency = k edges, where k is the 1-based MSB-first index of that slice.
//    - Equal operands still take NSLICE edges.
//  BRC_EARLY_EXIT_EN undefined: fixed NSLICE-edge latency for all operands.
//  Results are identical in both builds; only timing differs.
// TESTING
//  1. rs1=0x00000005, rs2=0x00000007, un=1 -> less=1, equal=0; o_valid 8 edges after accept in
//     both builds.
//  2. rs1=0xFFFFFFFF, rs2=0x00000001:
//     - un=0 -> less=1.
//     - un=1 -> less=0.
//     - Both: equal=0; latency 8 edges (base build) or 1 edge (BRC_EARLY_EXIT_EN).
//  3. rs1=rs2=0x80000000, un=0 and un=1 -> equal=1, less=0; 8 edges in both builds.
//  4. rs1=0x80000000, rs2=0x7FFFFFFF:
//     - un=0 -> less=1.
//     - un=1 -> less=0.
//     - Both: equal=0.
//  5. Back-pressure:
//     - Hold i_ready=0 for 5 cycles after o_valid -> outputs stable, o_ready=0, new i_valid ignored.
//     - Raise i_ready -> o_valid=0 and o_ready=1 after that edge.
//  6. Assert i_rst on the 3rd CMP edge -> no o_valid for that request; o_ready=1 after reset
//     release. Next request 0x10 vs 0x10 -> equal=1.

Source files
------------

// File: rtl/brc_serial_ctrl_if.sv
// Request/result handshake bundle for the serial branch comparator.
// Signal names carry the controller's point of view (i_ = into the controller).
interface brc_serial_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_rs1_data;
  logic [DATA_W-1:0] i_rs2_data;
  logic              i_br_un;
  logic              o_valid;
  logic              i_ready;
  logic              o_br_less;
  logic              o_br_equal;

  modport slave (
    input  i_valid, i_rs1_data, i_rs2_data, i_br_un, i_ready,
    output o_ready, o_valid, o_br_less, o_br_equal
  );

  modport master (
    output i_valid, i_rs1_data, i_rs2_data, i_br_un, i_ready,
    input  o_ready, o_valid, o_br_less, o_br_equal
  );
endinterface

// File: rtl/brc_serial_ctrl.sv
// Multi-cycle branch comparator: one SLICE_W-bit unsigned compare slice walked MSB-first.
// Optional macro BRC_EARLY_EXIT_EN finishes on the first unequal slice instead of always NSLICE edges.
module brc_serial_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  brc_serial_ctrl_if.slave bus
);
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NSLICE - 1);

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_slice
      $error("brc_serial_ctrl: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               decided_q, decided_d;
  logic               less_q, less_d;
  logic               accept;
  logic [DATA_W-1:0]  rs1_p0, rs2_p0;
  logic [SLICE_W-1:0] slice1, slice2;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  function automatic logic [DATA_W-1:0] bias_msb(input logic [DATA_W-1:0] v, input logic un);
    logic [DATA_W-1:0] r;
    r = v;
    r[DATA_W-1] = v[DATA_W-1] ^ ~un;
    return r;
  endfunction

  assign slice1 = rs1_p0[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice2 = rs2_p0[int'(idx_q)*SLICE_W +: SLICE_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    less_d    = less_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          accept    = 1'b1;
          idx_d     = IDX_MAX;
          decided_d = 1'b0;
          less_d    = 1'b0;
          state_d   = CMP;
        end
      end
      CMP: begin
        idx_d = idx_q - 1'b1;
        if (!decided_q && (slice1 != slice2)) begin
          decided_d = 1'b1;
          less_d    = (slice1 < slice2);
`ifdef BRC_EARLY_EXIT_EN
          state_d   = DONE;
`endif
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      decided_q <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      less_q    <= less_d;
    end
  end

  // Operand capture stage: data only, no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rs1_p0 <= bias_msb(bus.i_rs1_data, bus.i_br_un);
      rs2_p0 <= bias_msb(bus.i_rs2_data, bus.i_br_un);
    end
  end

  assign bus.o_ready    = (state_q == IDLE) && !i_rst;
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_br_less  = (state_q == DONE) && less_q;
  assign bus.o_br_equal = (state_q == DONE) && !decided_q;

endmodule
